// File: rtl/shift_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : shift_seq_pkg                                            |
// | Purpose : Shared types and default sizes for the shift sequencer:  |
// |           operation encoding, FSM state encoding, default widths.  |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
package shift_seq_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 3;

  // Operation carried by a command; values match the cmd_op encoding.
  typedef enum logic [1:0] {
    OP_ROL  = 2'b00,
    OP_ROR  = 2'b01,
    OP_ASR  = 2'b10,
    OP_LOAD = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_LOAD  = 2'b01,
    S_SHIFT = 2'b10,
    S_DONE  = 2'b11
  } state_t;

endpackage : shift_seq_pkg
`default_nettype wire

// File: rtl/shift_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : shift_sequencer                                          |
// | Purpose : Command-driven controller for an external load/rotate/   |
// |           arithmetic-shift register. Loads the register, steps it  |
// |           cmd_count times, then pulses result_valid.               |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
// | Ports                                                              |
// |   clock            in   rising-edge clock                          |
// |   reset            in   asynchronous active-low reset              |
// |   cmd_valid/ready  in/out command handshake                        |
// |   cmd_data         in   WIDTH value to load                        |
// |   cmd_op           in   00 ROL, 01 ROR, 10 ASR, 11 load only       |
// |   cmd_count        in   CNT_W number of shift steps                |
// |   q_in             in   register Q fed back                        |
// |   sr_loadn         out  register ParallelLoadn (0 = load)          |
// |   sr_rotate_right  out  register RotateRight                       |
// |   sr_asright       out  register ASRight                           |
// |   sr_data          out  register Data_IN                           |
// |   result_valid     out  one-cycle completion pulse                 |
// |   result_data      out  register value at completion               |
// +--------------------------------------------------------------------+
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] q_in,
  output logic             sr_loadn,
  output logic             sr_rotate_right,
  output logic             sr_asright,
  output logic [WIDTH-1:0] sr_data,
  output logic             result_valid,
  output logic [WIDTH-1:0] result_data
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] data_q;
  op_t              op_q;
  logic [CNT_W-1:0] count_q;

  // Single FSM process: state, shift counter and captured command.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      data_q  <= '0;
      op_q    <= OP_ROL;
      count_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // cmd_ready is implied by being in IDLE.
          if (cmd_valid) begin
            data_q  <= cmd_data;
            op_q    <= op_t'(cmd_op);
            count_q <= cmd_count;
            state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (count_q == '0 || op_q == OP_LOAD) begin
            state <= S_DONE;
          end else begin
            cnt   <= count_q;
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          cnt <= cnt - CNT_W'(1);
          // The step taken in this cycle is the last one requested.
          if (cnt == CNT_W'(1)) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Moore output decode. Outside SHIFT the register has no hold mode, so
  // it is fed its own output to freeze it (except during LOAD).
  always_comb begin
    cmd_ready       = 1'b0;
    sr_loadn        = 1'b0;
    sr_rotate_right = 1'b0;
    sr_asright      = 1'b0;
    sr_data         = q_in;
    result_valid    = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
      end
      S_LOAD: begin
        sr_data = data_q;
      end
      S_SHIFT: begin
        sr_loadn        = 1'b1;
        sr_rotate_right = (op_q == OP_ROR) || (op_q == OP_ASR);
        sr_asright      = (op_q == OP_ASR);
      end
      S_DONE: begin
        result_valid = 1'b1;
      end
      default: begin
        cmd_ready = 1'b0;
      end
    endcase
  end

  assign result_data = q_in;

endmodule : shift_sequencer
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : tb_shift_sequencer                                       |
// | Purpose : Self-checking bench: shift_sequencer driving a           |
// |           behavioural 8-bit load/rotate/ASR register.              |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module tb_shift_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_data;
  logic [1:0] cmd_op;
  logic [2:0] cmd_count;
  logic [7:0] q = 8'h3C;
  logic       sr_loadn;
  logic       sr_rotate_right;
  logic       sr_asright;
  logic [7:0] sr_data;
  logic       result_valid;
  logic [7:0] result_data;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  shift_sequencer #(.WIDTH(8), .CNT_W(3)) dut (
    .clock           (clock),
    .reset           (reset),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_data        (cmd_data),
    .cmd_op          (cmd_op),
    .cmd_count       (cmd_count),
    .q_in            (q),
    .sr_loadn        (sr_loadn),
    .sr_rotate_right (sr_rotate_right),
    .sr_asright      (sr_asright),
    .sr_data         (sr_data),
    .result_valid    (result_valid),
    .result_data     (result_data)
  );

  // The downstream register: parallel load, rotate left/right, ASR.
  always @(posedge clock) begin
    if (!sr_loadn)           q <= sr_data;
    else if (!sr_rotate_right) q <= {q[6:0], q[7]};
    else if (sr_asright)     q <= {q[7], q[7:1]};
    else                     q <= {q[0], q[7:1]};
  end

  // Reference: final register value from the command alone.
  function automatic logic [7:0] model(input logic [1:0] op, input logic [7:0] d,
                                       input logic [2:0] n);
    logic [15:0] w;
    logic [7:0]  r;
    w = {d, d};
    case (op)
      2'd0:    begin w = w << n; r = w[15:8]; end
      2'd1:    begin w = w >> n; r = w[7:0];  end
      2'd2:    r = 8'($signed(d) >>> n);
      default: r = d;
    endcase
    return r;
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk1({tag, "_ready"}, cmd_ready, 1'b1);
    chk1({tag, "_loadn"}, sr_loadn, 1'b0);
    chk1({tag, "_rr"}, sr_rotate_right, 1'b0);
    chk1({tag, "_asr"}, sr_asright, 1'b0);
    chk1({tag, "_rv"}, result_valid, 1'b0);
    chk8({tag, "_data"}, sr_data, q);
  endtask

  task automatic wait_ready(input string tag);
    int t = 0;
    while (!cmd_ready && t < 50) begin
      @(negedge clock);
      t++;
    end
    chk1({tag, "_ready_timeout"}, cmd_ready, 1'b1);
  endtask

  // One command, called at a negedge; returns at a negedge in IDLE.
  task automatic send(input string tag, input logic [1:0] op, input logic [7:0] d,
                      input logic [2:0] n);
    int lat;
    logic [7:0] exp;
    exp = model(op, d, n);
    lat = (n == 3'd0 || op == 2'd3) ? 2 : int'(n) + 2;
    wait_ready(tag);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    cmd_count = n;
    @(negedge clock);
    cmd_valid = 1'b0;
    cmd_data  = $urandom;
    for (int i = 1; i <= lat; i++) begin
      if (i > 1) @(negedge clock);
      chk1({tag, "_busy"}, cmd_ready, 1'b0);
      if (i == 2 && lat > 2) begin
        chk1({tag, "_shift_loadn"}, sr_loadn, 1'b1);
        chk1({tag, "_shift_rr"}, sr_rotate_right, op != 2'd0);
        chk1({tag, "_shift_asr"}, sr_asright, op == 2'd2);
      end
      if (i < lat) begin
        chk1({tag, "_early_rv"}, result_valid, 1'b0);
      end else begin
        chk1({tag, "_rv"}, result_valid, 1'b1);
        chk8({tag, "_result"}, result_data, exp);
      end
    end
    @(negedge clock);
    chk1({tag, "_rv_drop"}, result_valid, 1'b0);
    chk1({tag, "_ready_back"}, cmd_ready, 1'b1);
  endtask

  initial begin
    int         accepted;
    int         pulses;
    logic       acc_now;
    logic [7:0] res[$];
    logic [7:0] qs;

    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
    cmd_op    = 2'd0;
    cmd_count = 3'd0;

    // Reset held for three cycles, then ten idle cycles with Q frozen.
    repeat (3) @(negedge clock);
    chk_idle_outputs("reset");
    reset = 1'b1;
    @(negedge clock);
    chk_idle_outputs("post_reset");
    repeat (10) @(negedge clock);
    chk8("idle_hold_q", q, 8'h3C);

    // Directed cases from the plan.
    send("ror_b4", 2'd1, 8'hB4, 3'd3);
    chk8("ror_b4_q", q, 8'h96);
    send("asr_90", 2'd2, 8'h90, 3'd2);
    chk8("asr_90_q", q, 8'hE4);
    send("asr_40", 2'd2, 8'h40, 3'd2);
    chk8("asr_40_q", q, 8'h10);
    send("rol_81_1", 2'd0, 8'h81, 3'd1);
    chk8("rol_81_1_q", q, 8'h03);
    send("rol_81_0", 2'd0, 8'h81, 3'd0);
    chk8("rol_81_0_q", q, 8'h81);
    send("load_5a", 2'd3, 8'h5A, 3'd5);
    chk8("load_5a_q", q, 8'h5A);

    // Backpressure: cmd_valid stays high across two commands.
    accepted  = 0;
    pulses    = 0;
    cmd_valid = 1'b1;
    cmd_op    = 2'd1;
    cmd_data  = 8'h01;
    cmd_count = 3'd1;
    for (int c = 0; c < 30; c++) begin
      if (result_valid) begin
        pulses++;
        res.push_back(result_data);
      end
      acc_now = cmd_valid && cmd_ready;
      if (acc_now) accepted++;
      @(negedge clock);
      if (acc_now) begin
        if (accepted == 1) begin
          cmd_op    = 2'd0;
          cmd_data  = 8'h01;
          cmd_count = 3'd7;
        end else begin
          cmd_valid = 1'b0;
        end
      end
    end
    cmd_valid = 1'b0;
    chk8("bp_accepted", 8'(accepted), 8'd2);
    chk8("bp_pulses", 8'(pulses), 8'd2);
    chk8("bp_res0", (res.size() > 0) ? res[0] : 8'hxx, 8'h80);
    chk8("bp_res1", (res.size() > 1) ? res[1] : 8'hxx, 8'h80);

    // Reset during the shift sequence: three shift edges have happened.
    wait_ready("mid");
    cmd_valid = 1'b1;
    cmd_op    = 2'd1;
    cmd_data  = 8'hF0;
    cmd_count = 3'd7;
    @(negedge clock);
    cmd_valid = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk_idle_outputs("mid_reset");
    pulses = 0;
    repeat (2) begin
      @(negedge clock);
      if (result_valid) pulses++;
    end
    reset = 1'b1;
    repeat (3) begin
      @(negedge clock);
      if (result_valid) pulses++;
    end
    chk8("mid_no_pulse", 8'(pulses), 8'd0);
    chk8("mid_q_frozen", q, 8'h1E);
    send("after_reset", 2'd1, 8'h5A, 3'd4);

    // Randomized commands against the reference model.
    for (int k = 0; k < 25; k++) begin
      logic [1:0] rop;
      logic [7:0] rd;
      logic [2:0] rn;
      rop = 2'($urandom_range(0, 3));
      rd  = 8'($urandom);
      rn  = 3'($urandom_range(0, 7));
      send("rand", rop, rd, rn);
      qs = q;
      repeat (int'($urandom_range(0, 3))) @(negedge clock);
      chk8("rand_idle_hold", q, qs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_shift_sequencer
`default_nettype wire
